// File: rtl/eqn_dr_hs.sv
// rtl/eqn_dr_hs.sv - dual-rail equality comparator stage with completion detection
// and a four-phase return-to-zero handshake, registered on a single clock.
module eqn_dr_hs #(
  parameter int    WIDTH    = 4,
  parameter string ENC      = "TP",
  parameter string MODE     = "EQ",
  parameter int    CNT_W    = 8,
  localparam int   RAIL_NUM = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [WIDTH*RAIL_NUM-1:0] in0,
  input  logic [WIDTH*RAIL_NUM-1:0] in1,
  output logic [RAIL_NUM-1:0]       out,
  output logic                      ack_up,
  input  logic                      ack_dn,
  output logic                      err,
  output logic [CNT_W-1:0]          cnt
);

  localparam bit INVERT = (MODE == "NEQ");

  if (ENC != "TP") begin : g_enc_check
    $error("eqn_dr_hs: only the TP rail encoding is implemented");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RTZ  = 2'd2
  } state_t;

  logic [WIDTH-1:0] valid0, valid1, null0, null1, ill0, ill1, val0, val1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_decode
    assign valid0[i] = in0[2*i+1] ^ in0[2*i];
    assign valid1[i] = in1[2*i+1] ^ in1[2*i];
    assign null0[i]  = ~(in0[2*i+1] | in0[2*i]);
    assign null1[i]  = ~(in1[2*i+1] | in1[2*i]);
    assign ill0[i]   = in0[2*i+1] & in0[2*i];
    assign ill1[i]   = in1[2*i+1] & in1[2*i];
    assign val0[i]   = in0[2*i+1];
    assign val1[i]   = in1[2*i+1];
  end

  logic complete, all_null, illegal, eq, res;

  assign complete = (&valid0) & (&valid1);
  assign all_null = (&null0) & (&null1);
  assign illegal  = (|ill0) | (|ill1);
  // Bit values are only meaningful once complete, which gates every capture.
  assign eq       = &(val0 ~^ val1);
  assign res      = INVERT ? ~eq : eq;

  state_t                state_q, state_d;
  logic [RAIL_NUM-1:0]   out_q, out_d;
  logic                  ack_up_q, ack_up_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    ack_up_d = ack_up_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    if (en) begin
      if (illegal) begin
        err_d = 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (complete && !ack_dn) begin
            state_d  = ST_DATA;
            out_d    = res ? 2'b10 : 2'b01;
            ack_up_d = 1'b1;
          end
        end
        ST_DATA: begin
          if (ack_dn && all_null) begin
            state_d  = ST_RTZ;
            out_d    = 2'b00;
            ack_up_d = 1'b0;
          end
        end
        ST_RTZ: begin
          if (!ack_dn) begin
            state_d = ST_IDLE;
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d  = ST_IDLE;
          out_d    = 2'b00;
          ack_up_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      out_q    <= 2'b00;
      ack_up_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      ack_up_q <= ack_up_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out    = out_q;
  assign ack_up = ack_up_q;
  assign err    = err_q;
  assign cnt    = cnt_q;

endmodule
